// File: rtl/ws2812_rx.sv
// WS2812 NRZ line decoder: recovers 24-bit GRB words into a small FWFT FIFO
// and reports frame boundaries from the latch (reset-low) gap.
module ws2812_rx #(
    parameter int THRESH     = 15,
    parameter int MIN_HIGH   = 4,
    parameter int MAX_HIGH   = 40,
    parameter int RESET_LOW  = 1250,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] data,
    output logic        valid,
    input  logic        ready,
    output logic        frame_done,
    output logic [9:0]  frame_pixels,
    output logic        err_glitch,
    output logic        err_overflow,
    input  logic        err_clr
);

    localparam int CW = $clog2(RESET_LOW + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] THRESH_C    = CW'(THRESH);
    localparam logic [CW-1:0] MIN_HIGH_C  = CW'(MIN_HIGH);
    localparam logic [CW-1:0] MAX_HIGH_C  = CW'(MAX_HIGH);
    localparam logic [CW-1:0] RESET_LOW_C = CW'(RESET_LOW);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          din_s1;
    logic          din_s2;
    logic          din_d;
    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [22:0]   shreg;
    logic [4:0]    bit_cnt;
    logic [9:0]    pix_cnt;

    logic          bit_val;
    logic          shift_en;
    logic          discard;
    logic          glitch_set;
    logic          frame_end;
    logic          word_done;
    logic [23:0]   push_word;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          overflow;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
            din_d  <= 1'b0;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
            din_d  <= din_s2;
        end
    end

    assign rise = din_s2 & ~din_d;
    assign fall = ~din_s2 & din_d;

    // Level-duration counter, restarted on every line transition.
    always_ff @(posedge clk_25mhz) begin
        if (reset || rise || fall) begin
            cnt <= '0;
        end else if (cnt != RESET_LOW_C) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        discard    = 1'b0;
        glitch_set = 1'b0;
        frame_end  = 1'b0;
        bit_val    = (cnt >= THRESH_C);
        case (state)
            SYNC: begin
                if (cnt >= RESET_LOW_C && (!din_s2 || rise)) begin
                    state_next = rise ? HIGH : IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (cnt < MIN_HIGH_C) begin
                        glitch_set = 1'b1;
                        discard    = 1'b1;
                        state_next = SYNC;
                    end else begin
                        shift_en   = 1'b1;
                        state_next = LOW;
                    end
                end else if (cnt >= MAX_HIGH_C) begin
                    glitch_set = 1'b1;
                    discard    = 1'b1;
                    state_next = SYNC;
                end
            end
            LOW: begin
                if (cnt >= RESET_LOW_C) begin
                    frame_end  = 1'b1;
                    glitch_set = (bit_cnt != 5'd0);
                    state_next = rise ? HIGH : IDLE;
                end else if (rise) begin
                    state_next = HIGH;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    assign word_done = shift_en && (bit_cnt == 5'd23);
    assign push_word = {shreg, bit_val};

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            err_glitch   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            frame_done <= frame_end && (pix_cnt != 10'd0);
            if (shift_en) begin
                shreg   <= {shreg[21:0], bit_val};
                bit_cnt <= word_done ? 5'd0 : bit_cnt + 5'd1;
            end
            if (discard) begin
                bit_cnt <= 5'd0;
            end
            if (word_done && pix_cnt != 10'h3ff) begin
                pix_cnt <= pix_cnt + 10'd1;
            end
            if (frame_end) begin
                bit_cnt <= 5'd0;
                pix_cnt <= 10'd0;
                if (pix_cnt != 10'd0) begin
                    frame_pixels <= pix_cnt;
                end
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            err_glitch   <= glitch_set | (err_glitch & ~err_clr);
            err_overflow <= overflow | (err_overflow & ~err_clr);
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid    = ~empty;
    assign pop      = valid & ready;
    assign wr_en    = word_done && (!full || pop);
    assign overflow = word_done && full && !pop;
    assign data     = valid ? mem[rd_ptr[AW-1:0]] : 24'd0;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; valid and the data mux hide stale entries.
    always_ff @(posedge clk_25mhz) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed-plus-random bench for ws2812_rx; a word-level queue model predicts
// FIFO contents, overflow and frame counts from what was put on the line.
module tb_ws2812_rx;

    localparam int THRESH   = 15;
    localparam int MIN_HIGH = 4;
    localparam int MAX_HIGH = 40;
    localparam int DEPTH    = 4;
    localparam int GAP      = 1260;

    logic        clk_25mhz = 1'b0;
    logic        reset;
    logic        din;
    logic        ready;
    logic        err_clr;
    logic [23:0] data;
    logic        valid;
    logic        frame_done;
    logic [9:0]  frame_pixels;
    logic        err_glitch;
    logic        err_overflow;

    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    int          fd_count = 0;
    logic [9:0]  fd_pixels = '0;
    logic [23:0] exp_q [$];
    logic        model_overflow = 1'b0;

    ws2812_rx dut (
        .clk_25mhz   (clk_25mhz),
        .reset       (reset),
        .din         (din),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_done  (frame_done),
        .frame_pixels(frame_pixels),
        .err_glitch  (err_glitch),
        .err_overflow(err_overflow),
        .err_clr     (err_clr)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_25mhz);
            #5;
        end
    endtask

    task automatic send_bit(input logic b, input int h, input int l);
        din = 1'b1;
        tick(h);
        din = 1'b0;
        tick(l);
    endtask

    task automatic send_fixed(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i], w[i] ? 20 : 10, w[i] ? 11 : 21);
        end
    endtask

    // MSB-first, first nbits of w, with random high/low times clear of the thresholds.
    task automatic send_rand(input logic [23:0] w, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            int h;
            int l;
            h = w[23-k] ? int'($urandom_range(MAX_HIGH - 3, THRESH + 2))
                        : int'($urandom_range(THRESH - 3, MIN_HIGH + 2));
            l = int'($urandom_range(20, 6));
            send_bit(w[23-k], h, l);
        end
    endtask

    task automatic model_push(input logic [23:0] w);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
        end else begin
            model_overflow = 1'b1;
        end
    endtask

    task automatic gap();
        din = 1'b0;
        tick(GAP);
    endtask

    always @(negedge clk_25mhz) begin
        if (frame_done === 1'b1) begin
            fd_count++;
            fd_pixels = frame_pixels;
        end
        if (valid === 1'b1 && ready === 1'b1) begin
            pops++;
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {8'h00, data}, 32'hffff_ffff);
            end else begin
                check("pop_data", {8'h00, data}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [23:0] w;
        int          n;
        int          exp_pops;
        int          exp_fd;

        reset   = 1'b1;
        din     = 1'b0;
        ready   = 1'b0;
        err_clr = 1'b0;
        tick(3);
        check("rst_data", {8'h00, data}, 32'h0);
        check("rst_valid", valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_pixels", frame_pixels, 0);
        check("rst_err_glitch", err_glitch, 0);
        check("rst_err_overflow", err_overflow, 0);
        reset = 1'b0;

        // 1: single fixed-timing word, latency, frame end
        gap();
        w = 24'h00ff00;
        model_push(w);
        for (int i = 23; i >= 1; i--) begin
            send_bit(w[i], w[i] ? 20 : 10, w[i] ? 11 : 21);
        end
        din = 1'b1;
        tick(10);
        din = 1'b0;
        tick(2);
        check("t1_valid_2_edges", valid, 0);
        tick(1);
        check("t1_valid_3_edges", valid, 1);
        check("t1_data", {8'h00, data}, 32'h0000_ff00);
        tick(18);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("t1_pops", pops, 1);
        gap();
        check("t1_frame_done", fd_count, 1);
        check("t1_pulse_pixels", fd_pixels, 1);
        check("t1_frame_pixels", frame_pixels, 1);
        exp_pops = 1;
        exp_fd   = 1;

        // 2: 16 alternating pixels streamed straight through
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = i[0] ? 24'h000000 : 24'hff00ff;
            model_push(w);
            send_fixed(w);
        end
        gap();
        exp_pops += 16;
        exp_fd++;
        check("t2_pops", pops, exp_pops);
        check("t2_model_drained", exp_q.size(), 0);
        check("t2_frame_done", fd_count, exp_fd);
        check("t2_frame_pixels", frame_pixels, 16);
        check("t2_err_glitch", err_glitch, 0);
        check("t2_err_overflow", err_overflow, 0);

        // 3: consumer stalled, 6 pixels into a 4-deep FIFO
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w = 24'($urandom);
            model_push(w);
            send_rand(w, 24);
        end
        check("t3_valid_held", valid, 1);
        check("t3_err_overflow", err_overflow, model_overflow);
        gap();
        exp_fd++;
        check("t3_frame_done", fd_count, exp_fd);
        check("t3_frame_pixels", frame_pixels, 6);
        ready = 1'b1;
        tick(8);
        ready = 1'b0;
        exp_pops += DEPTH;
        check("t3_pops", pops, exp_pops);
        check("t3_model_drained", exp_q.size(), 0);
        check("t3_valid_empty", valid, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t3_overflow_cleared", err_overflow, 0);

        // 4: glitch mid-word forces resync; junk before the gap is ignored
        ready = 1'b1;
        send_rand(24'($urandom), 5);
        din = 1'b1;
        tick(3);
        din = 1'b0;
        tick(6);
        check("t4_err_glitch", err_glitch, 1);
        send_rand(24'($urandom), 24);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_glitch_cleared", err_glitch, 0);
        gap();
        check("t4_no_junk_pop", pops, exp_pops);
        check("t4_no_frame_done", fd_count, exp_fd);
        w = 24'($urandom);
        model_push(w);
        send_rand(w, 24);
        gap();
        exp_pops++;
        exp_fd++;
        check("t4_pops", pops, exp_pops);
        check("t4_frame_done", fd_count, exp_fd);
        check("t4_frame_pixels", frame_pixels, 1);
        check("t4_err_glitch_stays_0", err_glitch, 0);

        // 5: partial word at latch
        send_rand(24'($urandom), 12);
        gap();
        check("t5_err_glitch", err_glitch, 1);
        check("t5_no_pop", pops, exp_pops);
        check("t5_no_frame_done", fd_count, exp_fd);
        w = 24'($urandom);
        model_push(w);
        send_rand(w, 24);
        gap();
        exp_pops++;
        exp_fd++;
        check("t5_pops", pops, exp_pops);
        check("t5_frame_done", fd_count, exp_fd);
        check("t5_frame_pixels", frame_pixels, 1);
        check("t5_err_glitch_sticky", err_glitch, 1);

        // 6: reset mid-word
        send_rand(24'($urandom), 10);
        reset = 1'b1;
        tick(2);
        check("t6_data", {8'h00, data}, 32'h0);
        check("t6_valid", valid, 0);
        check("t6_frame_done", frame_done, 0);
        check("t6_frame_pixels", frame_pixels, 0);
        check("t6_err_glitch", err_glitch, 0);
        check("t6_err_overflow", err_overflow, 0);
        reset = 1'b0;
        gap();
        w = 24'($urandom);
        model_push(w);
        send_rand(w, 24);
        gap();
        exp_pops++;
        exp_fd++;
        check("t6_pops", pops, exp_pops);
        check("t6_frame_done_after", fd_count, exp_fd);
        check("t6_frame_pixels_after", frame_pixels, 1);

        // 7: random frames
        for (int f = 0; f < 3; f++) begin
            n = int'($urandom_range(5, 1));
            for (int i = 0; i < n; i++) begin
                w = 24'($urandom);
                model_push(w);
                send_rand(w, 24);
            end
            gap();
            exp_pops += n;
            exp_fd++;
            check("t7_frame_done", fd_count, exp_fd);
            check("t7_frame_pixels", frame_pixels, n);
        end
        check("t7_pops", pops, exp_pops);
        check("t7_model_drained", exp_q.size(), 0);
        check("t7_err_overflow", err_overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
